// File: rtl/pe_seq_pkg.sv
// Shared types for the PE MAC sequencer.
//   state_t : sequencer FSM states
//   token_t : per-read marker carried alongside buffer read latency
//   ADDR_W_DEF / CNT_W_DEF : default address and count field widths
package pe_seq_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // first: term 0 of an output, last: term L-1 of an output
   typedef struct packed {
      logic first;
      logic last;
   } token_t;

endpackage

// File: rtl/pe_seq_delay.sv
// Fixed-depth shift register that delays read tokens (and their valid bit)
// by the buffer read latency, so PE control lines up with returning data.
//   clk, reset : clock, synchronous active-high reset (clears every stage)
//   in_valid   : a read was issued this cycle
//   in_tok     : token describing that read
//   out_valid  : read data is at the PE inputs this cycle
//   out_tok    : token for that data
module pe_seq_delay
   import pe_seq_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   in_valid,
   input  token_t in_tok,
   output logic   out_valid,
   output token_t out_tok
);

   logic   [DEPTH-1:0] valid_q, valid_d;
   token_t [DEPTH-1:0] tok_q, tok_d;

   // Shift one stage per cycle; stage 0 takes the new read.
   always_comb begin
      valid_d    = valid_q;
      tok_d      = tok_q;
      valid_d[0] = in_valid;
      tok_d[0]   = in_tok;
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1];
         tok_d[i]   = tok_q[i-1];
      end
   end

   // Stage registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         tok_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tok_q   <= tok_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_tok   = tok_q[DEPTH-1];

endmodule

// File: rtl/pe_mac_sequencer.sv
// Control sequencer for one multiply-accumulate PE.
// Per job it streams N outputs of L terms each: one IFM/weight read per cycle,
// pe_en/pe_finish aligned to the buffer read latency, and one OFM write per
// pe_valid returned by the PE.
//   start, cfg_*   : job request and job parameters (latched on start in IDLE)
//   ifm_*, wgt_*   : buffer read strobes and addresses (registered)
//   pe_en/finish   : PE accumulator clear / last-term markers
//   pe_valid       : PE result valid
//   ofm_wr_en/addr : OFM write strobe (pe_valid while busy) and address
//   busy, done     : job in progress, one-cycle completion pulse
module pe_mac_sequencer
   import pe_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_kernel_len,
   input  logic [CNT_W-1:0]  cfg_num_out,
   input  logic [ADDR_W-1:0] cfg_ifm_base,
   input  logic [ADDR_W-1:0] cfg_ifm_step,
   input  logic [ADDR_W-1:0] cfg_wgt_base,
   input  logic [ADDR_W-1:0] cfg_ofm_base,
   output logic              ifm_rd_en,
   output logic [ADDR_W-1:0] ifm_addr,
   output logic              wgt_rd_en,
   output logic [ADDR_W-1:0] wgt_addr,
   output logic              pe_en,
   output logic              pe_finish,
   input  logic              pe_valid,
   output logic              ofm_wr_en,
   output logic [ADDR_W-1:0] ofm_addr,
   output logic              busy,
   output logic              done
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  kern_len_q, kern_len_d;
   logic [CNT_W-1:0]  num_out_q, num_out_d;
   logic [ADDR_W-1:0] ifm_step_q, ifm_step_d;
   logic [ADDR_W-1:0] wgt_base_q, wgt_base_d;
   logic [CNT_W-1:0]  k_q, k_d;
   logic [CNT_W-1:0]  o_q, o_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d;
   logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
   logic              rd_en_q, rd_en_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0] ofm_addr_q, ofm_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic   last_term_s, last_read_s, wr_s;
   token_t tok_in_s, tok_out_s;
   logic   tok_valid_s;

   assign last_term_s = (k_q == kern_len_q - CNT_W'(1));
   assign last_read_s = last_term_s && (o_q == num_out_q - CNT_W'(1));
   assign wr_s        = pe_valid && busy_q;

   // Tokens are gated by the read strobe so idle cycles carry no markers.
   assign tok_in_s.first = rd_en_q && (k_q == CNT_W'(0));
   assign tok_in_s.last  = rd_en_q && last_term_s;

   pe_seq_delay #(.DEPTH(RD_LAT)) u_delay (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_en_q),
      .in_tok    (tok_in_s),
      .out_valid (tok_valid_s),
      .out_tok   (tok_out_s)
   );

   // Next-state, counter and address computation.
   always_comb begin
      state_d    = state_q;
      kern_len_d = kern_len_q;
      num_out_d  = num_out_q;
      ifm_step_d = ifm_step_q;
      wgt_base_d = wgt_base_q;
      k_d        = k_q;
      o_d        = o_q;
      row_base_d = row_base_q;
      ifm_addr_d = ifm_addr_q;
      wgt_addr_d = wgt_addr_q;
      rd_en_d    = 1'b0;
      wr_cnt_d   = wr_cnt_q;
      ofm_addr_d = ofm_addr_q;

      // Writes are counted independently of the read schedule.
      if (wr_s) begin
         wr_cnt_d   = wr_cnt_q + CNT_W'(1);
         ofm_addr_d = ofm_addr_q + ADDR_W'(1);
      end else begin
         wr_cnt_d   = wr_cnt_q;
         ofm_addr_d = ofm_addr_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               kern_len_d = cfg_kernel_len;
               ifm_step_d = cfg_ifm_step;
               wgt_base_d = cfg_wgt_base;
               k_d        = CNT_W'(0);
               o_d        = CNT_W'(0);
               row_base_d = cfg_ifm_base;
               ifm_addr_d = cfg_ifm_base;
               wgt_addr_d = cfg_wgt_base;
               wr_cnt_d   = CNT_W'(0);
               ofm_addr_d = cfg_ofm_base;
               // An empty job expects zero writes, so DRAIN retires it on
               // the following cycle without touching buffers or the PE.
               if ((cfg_kernel_len == CNT_W'(0)) || (cfg_num_out == CNT_W'(0))) begin
                  num_out_d = CNT_W'(0);
                  state_d   = DRAIN;
               end else begin
                  num_out_d = cfg_num_out;
                  rd_en_d   = 1'b1;
                  state_d   = RUN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // rd_en_q is high for the whole of RUN; k_q/o_q name the read
            // currently on the address outputs.
            if (last_read_s) begin
               state_d = DRAIN;
            end else begin
               rd_en_d = 1'b1;
               if (last_term_s) begin
                  k_d        = CNT_W'(0);
                  o_d        = o_q + CNT_W'(1);
                  row_base_d = row_base_q + ifm_step_q;
                  ifm_addr_d = row_base_q + ifm_step_q;
                  wgt_addr_d = wgt_base_q;
               end else begin
                  k_d        = k_q + CNT_W'(1);
                  ifm_addr_d = ifm_addr_q + ADDR_W'(1);
                  wgt_addr_d = wgt_addr_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            if (wr_cnt_d == num_out_q) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         kern_len_q <= '0;
         num_out_q  <= '0;
         ifm_step_q <= '0;
         wgt_base_q <= '0;
         k_q        <= '0;
         o_q        <= '0;
         row_base_q <= '0;
         ifm_addr_q <= '0;
         wgt_addr_q <= '0;
         rd_en_q    <= 1'b0;
         wr_cnt_q   <= '0;
         ofm_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         kern_len_q <= kern_len_d;
         num_out_q  <= num_out_d;
         ifm_step_q <= ifm_step_d;
         wgt_base_q <= wgt_base_d;
         k_q        <= k_d;
         o_q        <= o_d;
         row_base_q <= row_base_d;
         ifm_addr_q <= ifm_addr_d;
         wgt_addr_q <= wgt_addr_d;
         rd_en_q    <= rd_en_d;
         wr_cnt_q   <= wr_cnt_d;
         ofm_addr_q <= ofm_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ifm_rd_en = rd_en_q;
   assign wgt_rd_en = rd_en_q;
   assign ifm_addr  = ifm_addr_q;
   assign wgt_addr  = wgt_addr_q;
   assign pe_en     = tok_valid_s && tok_out_s.first;
   assign pe_finish = tok_valid_s && tok_out_s.last;
   assign ofm_wr_en = wr_s;
   assign ofm_addr  = ofm_addr_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Self-checking bench for pe_mac_sequencer: an RD_LAT=1 and an RD_LAT=3
// instance share stimulus; a monitor logs events of the selected instance,
// which are compared against expectations pushed when each job is started.
module tb_pe_mac_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] cfg_kernel_len = 16'h0, cfg_num_out = 16'h0;
   logic [15:0] cfg_ifm_base = 16'h0, cfg_ifm_step = 16'h0;
   logic [15:0] cfg_wgt_base = 16'h0, cfg_ofm_base = 16'h0;

   logic        rd1, wrd1, en1, fin1, val1, wr1, busy1, done1;
   logic [15:0] ifma1, wgta1, ofma1;
   logic        rd3, wrd3, en3, fin3, val3, wr3, busy3, done3;
   logic [15:0] ifma3, wgta3, ofma3;

   int          cyc = 0;
   int          t0 = 0;
   int          checks = 0;
   int          errors = 0;
   bit          mon_on = 1'b0;
   bit          track_busy = 1'b0;
   bit          sel = 1'b0;
   bit          prev_busy = 1'b0;
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];

   always #5 clk = ~clk;

   // Cycle counter: value n holds during the cycle after the n-th edge.
   always @(posedge clk) cyc <= cyc + 1;

   // PE model: pe_valid follows pe_finish by one cycle.
   always @(posedge clk) begin
      val1 <= reset ? 1'b0 : fin1;
      val3 <= reset ? 1'b0 : fin3;
   end

   pe_mac_sequencer #(.ADDR_W(16), .CNT_W(16), .RD_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start),
      .cfg_kernel_len(cfg_kernel_len), .cfg_num_out(cfg_num_out),
      .cfg_ifm_base(cfg_ifm_base), .cfg_ifm_step(cfg_ifm_step),
      .cfg_wgt_base(cfg_wgt_base), .cfg_ofm_base(cfg_ofm_base),
      .ifm_rd_en(rd1), .ifm_addr(ifma1), .wgt_rd_en(wrd1), .wgt_addr(wgta1),
      .pe_en(en1), .pe_finish(fin1), .pe_valid(val1),
      .ofm_wr_en(wr1), .ofm_addr(ofma1), .busy(busy1), .done(done1));

   pe_mac_sequencer #(.ADDR_W(16), .CNT_W(16), .RD_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start),
      .cfg_kernel_len(cfg_kernel_len), .cfg_num_out(cfg_num_out),
      .cfg_ifm_base(cfg_ifm_base), .cfg_ifm_step(cfg_ifm_step),
      .cfg_wgt_base(cfg_wgt_base), .cfg_ofm_base(cfg_ofm_base),
      .ifm_rd_en(rd3), .ifm_addr(ifma3), .wgt_rd_en(wrd3), .wgt_addr(wgta3),
      .pe_en(en3), .pe_finish(fin3), .pe_valid(val3),
      .ofm_wr_en(wr3), .ofm_addr(ofma3), .busy(busy3), .done(done3));

   logic        m_rd, m_wrd, m_en, m_fin, m_wr, m_busy, m_done;
   logic [15:0] m_ifm, m_wgt, m_ofm;
   assign m_rd   = sel ? rd3   : rd1;
   assign m_wrd  = sel ? wrd3  : wrd1;
   assign m_en   = sel ? en3   : en1;
   assign m_fin  = sel ? fin3  : fin1;
   assign m_wr   = sel ? wr3   : wr1;
   assign m_busy = sel ? busy3 : busy1;
   assign m_done = sel ? done3 : done1;
   assign m_ifm  = sel ? ifma3 : ifma1;
   assign m_wgt  = sel ? wgta3 : wgta1;
   assign m_ofm  = sel ? ofma3 : ofma1;

   // Event kinds: 1 read, 2 pe_en, 3 pe_finish, 4 write, 5 done,
   // 6 busy rise, 7 busy fall, 8 wgt_rd_en differs from ifm_rd_en.
   function automatic logic [63:0] ev(input logic [3:0] kind, input logic [15:0] c,
                                      input logic [15:0] a, input logic [15:0] b);
      return {12'h000, c, kind, a, b};
   endfunction

   // Monitor: log DUT events with cycle numbers relative to the start cycle.
   always @(negedge clk) begin
      logic [15:0] rel;
      if (mon_on) begin
         rel = 16'(cyc - t0);
         if (m_rd)           obs_q.push_back(ev(4'd1, rel, m_ifm, m_wgt));
         if (m_rd !== m_wrd) obs_q.push_back(ev(4'd8, rel, 16'h0, 16'h0));
         if (m_en)           obs_q.push_back(ev(4'd2, rel, 16'h0, 16'h0));
         if (m_fin)          obs_q.push_back(ev(4'd3, rel, 16'h0, 16'h0));
         if (m_wr)           obs_q.push_back(ev(4'd4, rel, m_ofm, 16'h0));
         if (m_done)         obs_q.push_back(ev(4'd5, rel, 16'h0, 16'h0));
         if (track_busy && m_busy && !prev_busy) obs_q.push_back(ev(4'd6, rel, 16'h0, 16'h0));
         if (track_busy && !m_busy && prev_busy) obs_q.push_back(ev(4'd7, rel, 16'h0, 16'h0));
      end
      prev_busy = m_busy;
   end

   // Expected event stream of a whole job, from the documented latency rules.
   task automatic push_expected(input int l, input int n, input logic [15:0] ib,
                                input logic [15:0] is, input logic [15:0] wb,
                                input logic [15:0] ob, input int lat, input bit trk);
      int c, dn;
      for (int j = 0; j < n; j++) begin
         for (int k = 0; k < l; k++) begin
            c = 1 + j * l + k;
            exp_q.push_back(ev(4'd1, 16'(c), 16'(ib + 16'(j) * is + 16'(k)), 16'(wb + 16'(k))));
            if (k == 0)     exp_q.push_back(ev(4'd2, 16'(c + lat), 16'h0, 16'h0));
            if (k == l - 1) begin
               exp_q.push_back(ev(4'd3, 16'(c + lat), 16'h0, 16'h0));
               exp_q.push_back(ev(4'd4, 16'(c + lat + 1), 16'(ob + 16'(j)), 16'h0));
            end
         end
      end
      dn = (l == 0 || n == 0) ? 2 : lat + n * l + 2;
      exp_q.push_back(ev(4'd5, 16'(dn), 16'h0, 16'h0));
      if (trk) begin
         exp_q.push_back(ev(4'd6, 16'd1, 16'h0, 16'h0));
         exp_q.push_back(ev(4'd7, 16'(dn), 16'h0, 16'h0));
      end
   endtask

   // Drive a start pulse with the given configuration; returns at rel cycle 1.
   task automatic start_job(input int l, input int n, input logic [15:0] ib,
                            input logic [15:0] is, input logic [15:0] wb,
                            input logic [15:0] ob, input int lat, input bit trk,
                            input bit push);
      @(negedge clk);
      exp_q.delete();
      obs_q.delete();
      t0 = cyc;
      track_busy = trk;
      mon_on = 1'b1;
      cfg_kernel_len = 16'(l);
      cfg_num_out = 16'(n);
      cfg_ifm_base = ib;
      cfg_ifm_step = is;
      cfg_wgt_base = wb;
      cfg_ofm_base = ob;
      start = 1'b1;
      if (push) push_expected(l, n, ib, is, wb, ob, lat, trk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_to(input int r);
      while (cyc - t0 < r) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rd1, wrd1, en1, fin1, wr1, busy1, done1, ifma1, wgta1, ofma1} !== 55'h0) begin
         errors++;
         $display("FAIL reset_lat1 outputs got %h want 0",
                  {rd1, wrd1, en1, fin1, wr1, busy1, done1, ifma1, wgta1, ofma1});
      end
      checks++;
      if ({rd3, wrd3, en3, fin3, wr3, busy3, done3, ifma3, wgta3, ofma3} !== 55'h0) begin
         errors++;
         $display("FAIL reset_lat3 outputs got %h want 0",
                  {rd3, wrd3, en3, fin3, wr3, busy3, done3, ifma3, wgta3, ofma3});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      sel = 1'b0;
      start_job(3, 2, 16'd0, 16'd3, 16'd16, 16'd32, 1, 1'b1, 1'b1);
      wait_to(13);
      exp_q.sort();
      obs_q.sort();
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL basic event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [63:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL basic event got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_kernel_len_one;
      sel = 1'b0;
      start_job(1, 4, 16'd100, 16'd2, 16'd7, 16'd200, 1, 1'b1, 1'b1);
      wait_to(11);
      exp_q.sort();
      obs_q.sort();
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL l1 event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [63:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL l1 event got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_zero_job;
      sel = 1'b0;
      for (int z = 0; z < 2; z++) begin
         if (z == 0) start_job(0, 5, 16'd1, 16'd1, 16'd1, 16'd1, 1, 1'b0, 1'b1);
         else        start_job(4, 0, 16'd1, 16'd1, 16'd1, 16'd1, 1, 1'b0, 1'b1);
         wait_to(6);
         exp_q.sort();
         obs_q.sort();
         checks++;
         if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL zero%0d event_count got %0d want %0d", z, obs_q.size(), exp_q.size());
         end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [63:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL zero%0d event got %h want %h", z, o, e);
            end
         end
      end
   endtask

   task automatic test_start_while_busy;
      sel = 1'b0;
      start_job(3, 3, 16'd10, 16'd5, 16'd40, 16'd100, 1, 1'b1, 1'b1);
      wait_to(3);
      cfg_kernel_len = 16'd1;
      cfg_num_out = 16'd1;
      cfg_ifm_base = 16'h0500;
      cfg_ifm_step = 16'd9;
      cfg_wgt_base = 16'h0600;
      cfg_ofm_base = 16'h0700;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(16);
      exp_q.sort();
      obs_q.sort();
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL restart event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [63:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL restart event got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_reset_mid_job;
      sel = 1'b0;
      start_job(4, 3, 16'd0, 16'd4, 16'd8, 16'd50, 1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++)
         exp_q.push_back(ev(4'd1, 16'(k + 1), 16'(k), 16'(8 + k)));
      exp_q.push_back(ev(4'd2, 16'd2, 16'h0, 16'h0));
      exp_q.push_back(ev(4'd6, 16'd1, 16'h0, 16'h0));
      exp_q.push_back(ev(4'd7, 16'd4, 16'h0, 16'h0));
      wait_to(3);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({rd1, wrd1, en1, fin1, wr1, busy1, done1, ifma1, wgta1, ofma1} !== 55'h0) begin
         errors++;
         $display("FAIL midreset outputs got %h want 0",
                  {rd1, wrd1, en1, fin1, wr1, busy1, done1, ifma1, wgta1, ofma1});
      end
      reset = 1'b0;
      wait_to(14);
      exp_q.sort();
      obs_q.sort();
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL midreset event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [63:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL midreset event got %h want %h", o, e);
         end
      end
      // A fresh job after the abort must run normally.
      start_job(3, 2, 16'd0, 16'd3, 16'd16, 16'd32, 1, 1'b1, 1'b1);
      wait_to(13);
      exp_q.sort();
      obs_q.sort();
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL after_reset event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [63:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL after_reset event got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_wrap_lat3;
      sel = 1'b1;
      start_job(4, 2, 16'hFFFE, 16'd1, 16'hFFFD, 16'hFFFF, 3, 1'b1, 1'b1);
      wait_to(17);
      exp_q.sort();
      obs_q.sort();
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL wrap3 event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [63:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wrap3 event got %h want %h", o, e);
         end
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_kernel_len_one();
      test_zero_job();
      test_start_while_busy();
      test_reset_mid_job();
      test_wrap_lat3();
      mon_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle %0d want completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
